mc_controller: RTL and testbench

//  Multicycle MIPS control unit: sequences pc, imem, instreg, regfile, ALU and data memory.

---
 rtl/mc_ctrl_if.sv | 41 ++++
 rtl/mc_controller.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_mc_controller.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_if.sv
// Control bundle between the multicycle MIPS controller and its datapath.
// The controller drives the master modport; the datapath uses the slave modport.
//   op, funct, zero  : datapath -> controller (instreg fields, ALU zero flag)
//   pcen .. illegal  : controller -> datapath (enables, mux selects, ALU op)
//   state            : controller -> observer (current FSM state, debug)
interface mc_ctrl_if;
  localparam int unsigned OP_W  = 6;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned ALU_W = 3;
  localparam int unsigned ST_W  = 4;

  logic [OP_W-1:0]  op;
  logic [OP_W-1:0]  funct;
  logic             zero;

  logic             pcen;
  logic             irwrite;
  logic             iord;
  logic             memwrite;
  logic             regwrite;
  logic             regdst;
  logic             memtoreg;
  logic             alusrca;
  logic [SEL_W-1:0] alusrcb;
  logic [SEL_W-1:0] pcsrc;
  logic [ALU_W-1:0] alucontrol;
  logic             illegal;
  logic [ST_W-1:0]  state;

  modport master (
    input  op, funct, zero,
    output pcen, irwrite, iord, memwrite, regwrite, regdst, memtoreg,
           alusrca, alusrcb, pcsrc, alucontrol, illegal, state
  );

  modport slave (
    output op, funct, zero,
    input  pcen, irwrite, iord, memwrite, regwrite, regdst, memtoreg,
           alusrca, alusrcb, pcsrc, alucontrol, illegal, state
  );
endinterface

// File: rtl/mc_controller.sv
// Multicycle MIPS control unit: Moore main-decoder FSM plus a combinational
// ALU decoder. Sequences PC, instruction memory, instreg, register file, ALU
// and data memory, and folds wait states for clocked instruction/data memory.
//
// Parameters
//   IMEM_LAT : extra FETCH cycles before IR/PC update (0..7)
//   DMEM_LAT : extra MEMRD/MEMWR cycles (0..7)
// Optional feature
//   MC_BNE_EN : when defined, op 000101 (bne) is decoded into BNEEX;
//               otherwise bne is an illegal opcode.
// Ports
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : mc_ctrl_if.master -- op/funct/zero in; enables, selects,
//           alucontrol, illegal pulse and debug state out.
// All control outputs are Moore decodes of the state register (plus op/funct/
// zero where the datapath needs same-cycle response), so none are X after reset.
module mc_controller #(
  parameter int unsigned IMEM_LAT = 1,
  parameter int unsigned DMEM_LAT = 0
) (
  input  logic       clk,
  input  logic       reset,
  mc_ctrl_if.master  bus
);

  localparam int unsigned CNT_W = 3;
  localparam int unsigned OP_W  = 6;
  localparam int unsigned ALU_W = 3;
  localparam int unsigned SEL_W = 2;

  localparam logic [CNT_W-1:0] IMEM_LAST = CNT_W'(IMEM_LAT);
  localparam logic [CNT_W-1:0] DMEM_LAST = CNT_W'(DMEM_LAT);

  // Opcodes
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
`ifdef MC_BNE_EN
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
`endif

  // R-type function codes
  localparam logic [OP_W-1:0] FN_ADD = 6'b100000;
  localparam logic [OP_W-1:0] FN_SUB = 6'b100010;
  localparam logic [OP_W-1:0] FN_AND = 6'b100100;
  localparam logic [OP_W-1:0] FN_OR  = 6'b100101;
  localparam logic [OP_W-1:0] FN_SLT = 6'b101010;

  // ALU control codes
  localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

  // Mux select encodings
  localparam logic [SEL_W-1:0] SRCB_RT    = 2'b00;
  localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b01;
  localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b10;
  localparam logic [SEL_W-1:0] SRCB_IMMSH = 2'b11;
  localparam logic [SEL_W-1:0] PC_ALU     = 2'b00;
  localparam logic [SEL_W-1:0] PC_ALUOUT  = 2'b01;
  localparam logic [SEL_W-1:0] PC_JUMP    = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
`ifdef MC_BNE_EN
    , S_BNEEX = 4'd12
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              pcwrite;
  logic              branch;
  logic              br_on_ne;
  logic              pcen;
  logic              irwrite;
  logic              iord;
  logic              memwrite;
  logic              regwrite;
  logic              regdst;
  logic              memtoreg;
  logic              alusrca;
  logic [SEL_W-1:0]  alusrcb;
  logic [SEL_W-1:0]  pcsrc;
  logic [ALU_W-1:0]  alucontrol;
  logic              illegal;

  // State and wait-counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and Moore output decode
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    br_on_ne   = 1'b0;
    irwrite    = 1'b0;
    iord       = 1'b0;
    memwrite   = 1'b0;
    regwrite   = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = SRCB_RT;
    pcsrc      = PC_ALU;
    alucontrol = ALU_AND;
    illegal    = 1'b0;

    unique case (state_q)
      // PC+4 computed every fetch cycle; IR and PC only load on the last one
      S_FETCH: begin
        alusrcb    = SRCB_FOUR;
        alucontrol = ALU_ADD;
        if (cnt_q == IMEM_LAST) begin
          irwrite = 1'b1;
          pcwrite = 1'b1;
          cnt_d   = '0;
          state_d = S_DECODE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Branch target precomputed into ALUOut while decoding
      S_DECODE: begin
        alusrcb    = SRCB_IMMSH;
        alucontrol = ALU_ADD;
        case (bus.op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
`ifdef MC_BNE_EN
          OP_BNE:       state_d = S_BNEEX;
`endif
          default: begin
            // Unknown opcode retires as a NOP
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end

      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_IMM;
        alucontrol = ALU_ADD;
        state_d    = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
      end

      S_MEMRD: begin
        iord = 1'b1;
        if (cnt_q == DMEM_LAST) begin
          cnt_d   = '0;
          state_d = S_MEMWB;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end

      // Address held for the whole access; the strobe only fires once
      S_MEMWR: begin
        iord = 1'b1;
        if (cnt_q == DMEM_LAST) begin
          memwrite = 1'b1;
          cnt_d    = '0;
          state_d  = S_FETCH;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_RTYPEEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_RT;
        case (bus.funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: begin
            // Unknown funct still executes as add and writes back
            alucontrol = ALU_ADD;
            illegal    = 1'b1;
          end
        endcase
        state_d = S_RTYPEWB;
      end

      S_RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end

      S_BEQEX: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_RT;
        alucontrol = ALU_SUB;
        pcsrc      = PC_ALUOUT;
        branch     = 1'b1;
        state_d    = S_FETCH;
      end

`ifdef MC_BNE_EN
      S_BNEEX: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_RT;
        alucontrol = ALU_SUB;
        pcsrc      = PC_ALUOUT;
        branch     = 1'b1;
        br_on_ne   = 1'b1;
        state_d    = S_FETCH;
      end
`endif

      S_ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_IMM;
        alucontrol = ALU_ADD;
        state_d    = S_ADDIWB;
      end

      S_ADDIWB: begin
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end

      S_JEX: begin
        pcsrc   = PC_JUMP;
        pcwrite = 1'b1;
        state_d = S_FETCH;
      end

      // Unreachable encodings recover to a clean fetch
      default: begin
        cnt_d   = '0;
        state_d = S_FETCH;
      end
    endcase

    // Reset is synchronous, so suppress every write in the cycle it is seen
    if (reset) begin
      pcwrite  = 1'b0;
      branch   = 1'b0;
      irwrite  = 1'b0;
      memwrite = 1'b0;
      regwrite = 1'b0;
      illegal  = 1'b0;
    end

    pcen = pcwrite | (branch & (br_on_ne ? ~bus.zero : bus.zero));
  end

  // Drive the interface
  assign bus.pcen       = pcen;
  assign bus.irwrite    = irwrite;
  assign bus.iord       = iord;
  assign bus.memwrite   = memwrite;
  assign bus.regwrite   = regwrite;
  assign bus.regdst     = regdst;
  assign bus.memtoreg   = memtoreg;
  assign bus.alusrca    = alusrca;
  assign bus.alusrcb    = alusrcb;
  assign bus.pcsrc      = pcsrc;
  assign bus.alucontrol = alucontrol;
  assign bus.illegal    = illegal;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Testbench for mc_controller (IMEM_LAT=1, DMEM_LAT=2). Each instruction
// pushes its expected per-cycle state/control trace into a queue; every
// negative clock edge pops one entry and compares state and masked controls.
module tb_mc_controller;

  localparam int unsigned IMEM_LAT = 1;
  localparam int unsigned DMEM_LAT = 2;

  localparam logic [3:0] S_FETCH   = 4'd0;
  localparam logic [3:0] S_DECODE  = 4'd1;
  localparam logic [3:0] S_MEMADR  = 4'd2;
  localparam logic [3:0] S_MEMRD   = 4'd3;
  localparam logic [3:0] S_MEMWB   = 4'd4;
  localparam logic [3:0] S_MEMWR   = 4'd5;
  localparam logic [3:0] S_RTYPEEX = 4'd6;
  localparam logic [3:0] S_RTYPEWB = 4'd7;
  localparam logic [3:0] S_BEQEX   = 4'd8;
  localparam logic [3:0] S_ADDIEX  = 4'd9;
  localparam logic [3:0] S_ADDIWB  = 4'd10;
  localparam logic [3:0] S_JEX     = 4'd11;
`ifdef MC_BNE_EN
  localparam logic [3:0] S_BNEEX   = 4'd12;
`endif

  typedef struct packed {
    logic       pcen;
    logic       irwrite;
    logic       iord;
    logic       memwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       illegal;
  } ctl_t;

  typedef struct packed {
    logic [3:0] st;
    ctl_t       v;
    ctl_t       m;
  } exp_t;

  logic clk;
  logic reset;

  mc_ctrl_if bus ();

  mc_controller #(
    .IMEM_LAT (IMEM_LAT),
    .DMEM_LAT (DMEM_LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    n_tests;
  int    n_fail;
  exp_t  exp_q[$];
  string tag_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic ctl_t observed();
    ctl_t c;
    c.pcen       = bus.pcen;
    c.irwrite    = bus.irwrite;
    c.iord       = bus.iord;
    c.memwrite   = bus.memwrite;
    c.regwrite   = bus.regwrite;
    c.regdst     = bus.regdst;
    c.memtoreg   = bus.memtoreg;
    c.alusrca    = bus.alusrca;
    c.alusrcb    = bus.alusrcb;
    c.pcsrc      = bus.pcsrc;
    c.alucontrol = bus.alucontrol;
    c.illegal    = bus.illegal;
    return c;
  endfunction

  function automatic ctl_t m_all();
    ctl_t m;
    m = '1;
    return m;
  endfunction

  // DECODE's ALU op is not pinned down, so it is left out of that compare
  function automatic ctl_t m_noalu();
    ctl_t m;
    m = '1;
    m.alucontrol = 3'b000;
    return m;
  endfunction

  function automatic ctl_t m_writes();
    ctl_t m;
    m = '0;
    m.pcen = 1'b1; m.irwrite = 1'b1; m.memwrite = 1'b1;
    m.regwrite = 1'b1; m.illegal = 1'b1;
    return m;
  endfunction

  task automatic push(input logic [3:0] st, input ctl_t v, input ctl_t m, input string tag);
    exp_t e;
    e.st = st;
    e.v  = v;
    e.m  = m;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Compare one queued entry per cycle, then step to just after the next
  // rising edge so the caller can change inputs for the following cycle.
  task automatic drain();
    exp_t  e;
    string t;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check({t, " state"}, 32'(bus.state), 32'(e.st));
      check({t, " ctl"}, 32'(observed() & e.m), 32'(e.v & e.m));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] funct, input logic zero);
    bus.op    = op;
    bus.funct = funct;
    bus.zero  = zero;
  endtask

  task automatic push_fetch(input string tag);
    ctl_t v;
    for (int unsigned i = 0; i <= IMEM_LAT; i++) begin
      v = '0;
      v.alusrcb    = 2'b01;
      v.alucontrol = 3'b010;
      v.irwrite    = (i == IMEM_LAT);
      v.pcen       = (i == IMEM_LAT);
      push(S_FETCH, v, m_all(), $sformatf("%s fetch%0d", tag, i));
    end
  endtask

  task automatic push_decode(input string tag, input logic ill);
    ctl_t v;
    v = '0;
    v.alusrcb = 2'b11;
    v.illegal = ill;
    push(S_DECODE, v, m_noalu(), {tag, " decode"});
  endtask

  task automatic push_memadr(input string tag);
    ctl_t v;
    v = '0;
    v.alusrca = 1'b1; v.alusrcb = 2'b10; v.alucontrol = 3'b010;
    push(S_MEMADR, v, m_all(), {tag, " memadr"});
  endtask

  task automatic do_lw();
    ctl_t v;
    drive(6'b100011, 6'b000000, 1'b0);
    push_fetch("lw");
    push_decode("lw", 1'b0);
    push_memadr("lw");
    for (int unsigned i = 0; i <= DMEM_LAT; i++) begin
      v = '0;
      v.iord = 1'b1;
      push(S_MEMRD, v, m_all(), $sformatf("lw memrd%0d", i));
    end
    v = '0;
    v.memtoreg = 1'b1; v.regwrite = 1'b1;
    push(S_MEMWB, v, m_all(), "lw memwb");
    drain();
  endtask

  task automatic do_sw();
    ctl_t v;
    drive(6'b101011, 6'b000000, 1'b0);
    push_fetch("sw");
    push_decode("sw", 1'b0);
    push_memadr("sw");
    for (int unsigned i = 0; i <= DMEM_LAT; i++) begin
      v = '0;
      v.iord     = 1'b1;
      v.memwrite = (i == DMEM_LAT);
      push(S_MEMWR, v, m_all(), $sformatf("sw memwr%0d", i));
    end
    drain();
  endtask

  task automatic do_rtype(input logic [5:0] funct, input logic [2:0] code,
                          input logic ill, input string tag);
    ctl_t v;
    drive(6'b000000, funct, 1'b0);
    push_fetch(tag);
    push_decode(tag, 1'b0);
    v = '0;
    v.alusrca = 1'b1; v.alucontrol = code; v.illegal = ill;
    push(S_RTYPEEX, v, m_all(), {tag, " ex"});
    v = '0;
    v.regdst = 1'b1; v.regwrite = 1'b1;
    push(S_RTYPEWB, v, m_all(), {tag, " wb"});
    drain();
  endtask

  task automatic do_beq(input logic zero);
    ctl_t v;
    drive(6'b000100, 6'b000000, zero);
    push_fetch("beq");
    push_decode("beq", 1'b0);
    v = '0;
    v.alusrca = 1'b1; v.alucontrol = 3'b110; v.pcsrc = 2'b01; v.pcen = zero;
    push(S_BEQEX, v, m_all(), zero ? "beq z1 ex" : "beq z0 ex");
    drain();
  endtask

  task automatic do_addi();
    ctl_t v;
    drive(6'b001000, 6'b000000, 1'b0);
    push_fetch("addi");
    push_decode("addi", 1'b0);
    v = '0;
    v.alusrca = 1'b1; v.alusrcb = 2'b10; v.alucontrol = 3'b010;
    push(S_ADDIEX, v, m_all(), "addi ex");
    v = '0;
    v.regwrite = 1'b1;
    push(S_ADDIWB, v, m_all(), "addi wb");
    drain();
  endtask

  task automatic do_j();
    ctl_t v;
    drive(6'b000010, 6'b000000, 1'b0);
    push_fetch("j");
    push_decode("j", 1'b0);
    v = '0;
    v.pcsrc = 2'b10; v.pcen = 1'b1;
    push(S_JEX, v, m_all(), "j ex");
    drain();
  endtask

  task automatic do_illegal_op(input logic [5:0] op, input string tag);
    drive(op, 6'b000000, 1'b0);
    push_fetch(tag);
    push_decode(tag, 1'b1);
    drain();
  endtask

  task automatic do_bne(input logic zero);
`ifdef MC_BNE_EN
    ctl_t v;
    drive(6'b000101, 6'b000000, zero);
    push_fetch("bne");
    push_decode("bne", 1'b0);
    v = '0;
    v.alusrca = 1'b1; v.alucontrol = 3'b110; v.pcsrc = 2'b01; v.pcen = ~zero;
    push(S_BNEEX, v, m_all(), zero ? "bne z1 ex" : "bne z0 ex");
    drain();
`else
    drive(6'b000101, 6'b000000, zero);
    push_fetch("bne");
    push_decode("bne", 1'b1);
    drain();
`endif
  endtask

  initial begin
    ctl_t v;
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    drive(6'b111111, 6'b111111, 1'b1);

    // Held in reset: FETCH with no writes and no illegal pulse
    v = '0;
    for (int i = 0; i < 3; i++) push(S_FETCH, v, m_writes(), $sformatf("reset%0d", i));
    drain();
    reset = 1'b0;

    do_lw();
    do_sw();
    do_rtype(6'b100000, 3'b010, 1'b0, "add");
    do_rtype(6'b100010, 3'b110, 1'b0, "sub");
    do_rtype(6'b100100, 3'b000, 1'b0, "and");
    do_rtype(6'b100101, 3'b001, 1'b0, "or");
    do_rtype(6'b101010, 3'b111, 1'b0, "slt");
    do_rtype(6'b111111, 3'b010, 1'b1, "badfn");
    do_beq(1'b1);
    do_beq(1'b0);
    do_addi();
    do_j();
    do_illegal_op(6'b111111, "op3f");
    do_bne(1'b0);
    do_bne(1'b1);

    // Reset asserted during RTYPEWB: the register write must be suppressed
    drive(6'b000000, 6'b100000, 1'b0);
    push_fetch("midrst");
    push_decode("midrst", 1'b0);
    v = '0;
    v.alusrca = 1'b1; v.alucontrol = 3'b010;
    push(S_RTYPEEX, v, m_all(), "midrst ex");
    drain();
    reset = 1'b1;
    v = '0;
    push(S_RTYPEWB, v, m_writes(), "midrst wb");
    drain();
    reset = 1'b0;

    // Must restart cleanly from FETCH
    do_lw();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: bench did not complete within 50000 time units");
    $fatal(1);
  end

endmodule
